// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : arb_pkg
// Brief   : Shared types, mux select codes and helpers for the 3-way arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic [1:0] SEL_D0 = 2'b00;
  localparam logic [1:0] SEL_D1 = 2'b01;
  localparam logic [1:0] SEL_D2 = 2'b10;

  // Requester index successor in {0,1,2}; 2 wraps to 0.
  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    return (v == SEL_D2) ? SEL_D0 : (v + 2'd1);
  endfunction

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    oh = 3'b000;
    case (idx)
      SEL_D0:  oh = 3'b001;
      SEL_D1:  oh = 3'b010;
      SEL_D2:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux3.sv
`default_nettype none
// ============================================================================
// Module : mux3
// Brief  : WIDTH-parameterised 3-input data mux; select 11 falls back to d0.
// Rev    : 1.0  initial release
// ============================================================================
module mux3
  import arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      SEL_D1:  y = d1;
      SEL_D2:  y = d2;
      default: y = d0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rr_pick3.sv
`default_nettype none
// ============================================================================
// Module : rr_pick3
// Brief  : Combinational round-robin pick among 3 requests, scanning from ptr+1.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick3
  import arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] w_c1;
  logic [1:0] w_c2;

  assign w_c1 = inc_mod3(ptr);
  assign w_c2 = inc_mod3(w_c1);

  // The last served requester (ptr) is considered last.
  always_comb begin
    found = 1'b0;
    idx   = SEL_D0;
    if (req[w_c1]) begin
      found = 1'b1;
      idx   = w_c1;
    end else if (req[w_c2]) begin
      found = 1'b1;
      idx   = w_c2;
    end else if (req[ptr]) begin
      found = 1'b1;
      idx   = ptr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter3.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter3
// Brief  : Burst-locked round-robin arbiter for three requesters with watchdog.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter3
  import arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req_valid,
  input  logic [2:0]       req_last,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [2:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [2:0]       grant,
  output logic             forced_release
);

  localparam int             CW    = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0]  c_MAX = CW'(MAX_BEATS);

  arb_state_t    r_state;
  arb_state_t    w_state_n;
  logic [2:0]    r_grant;
  logic [2:0]    w_grant_n;
  logic [1:0]    r_sel;
  logic [1:0]    w_sel_n;
  logic [1:0]    r_ptr;
  logic [1:0]    w_ptr_n;
  logic [CW-1:0] r_beat_cnt;
  logic [CW-1:0] w_beat_cnt_n;
  logic          r_forced_release;
  logic          w_forced_release_n;

  logic          w_found;
  logic [1:0]    w_idx;
  logic          w_busy;
  logic          w_own_valid;
  logic          w_own_last;
  logic          w_xfer;
  logic [CW-1:0] w_cnt_inc;
  logic          w_limit;

  rr_pick3 u_pick (
    .req   (req_valid),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  mux3 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel (r_sel),
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .y   (out_data)
  );

  // r_grant is zero while idle, so the owner masks also gate the handshake.
  assign w_busy      = (r_state == BUSY);
  assign w_own_valid = |(req_valid & r_grant);
  assign w_own_last  = |(req_last & r_grant);
  assign out_valid   = w_busy & w_own_valid;
  assign req_ready   = w_busy ? (r_grant & {3{out_ready}}) : 3'b000;
  assign w_xfer      = out_valid & out_ready;
  assign w_cnt_inc   = r_beat_cnt + CW'(1);
  assign w_limit     = (w_cnt_inc == c_MAX);

  assign grant          = r_grant;
  assign sel            = r_sel;
  assign forced_release = r_forced_release;

  always_comb begin
    w_state_n          = r_state;
    w_grant_n          = r_grant;
    w_sel_n            = r_sel;
    w_ptr_n            = r_ptr;
    w_beat_cnt_n       = r_beat_cnt;
    w_forced_release_n = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_n    = BUSY;
          w_grant_n    = idx_to_onehot(w_idx);
          w_sel_n      = w_idx;
          w_beat_cnt_n = '0;
        end
      end
      BUSY: begin
        if (w_xfer) begin
          if (w_own_last || w_limit) begin
            // A last beat that coincides with the limit is a normal release.
            w_state_n          = IDLE;
            w_ptr_n            = r_sel;
            w_grant_n          = 3'b000;
            w_beat_cnt_n       = '0;
            w_forced_release_n = ~w_own_last;
          end else begin
            w_beat_cnt_n = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_n = IDLE;
        w_grant_n = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_grant          <= 3'b000;
      r_sel            <= SEL_D0;
      r_ptr            <= SEL_D2;
      r_beat_cnt       <= '0;
      r_forced_release <= 1'b0;
    end else begin
      r_state          <= w_state_n;
      r_grant          <= w_grant_n;
      r_sel            <= w_sel_n;
      r_ptr            <= w_ptr_n;
      r_beat_cnt       <= w_beat_cnt_n;
      r_forced_release <= w_forced_release_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter3.sv
`default_nettype none
// ============================================================================
// Module : tb_rr_arbiter3
// Brief  : Self-checking bench for rr_arbiter3 with a reference model and scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter3;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       v = 3'b000;
  logic [2:0]       lst = 3'b000;
  logic [7:0]       dat [3];
  logic             ordy = 1'b0;
  logic [2:0]       req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       sel;
  logic [2:0]       grant;
  logic             forced_release;

  rr_arbiter3 #(
    .WIDTH     (WIDTH),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (v),
    .req_last       (lst),
    .d0             (dat[0]),
    .d1             (dat[1]),
    .d2             (dat[2]),
    .req_ready      (req_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (ordy),
    .sel            (sel),
    .grant          (grant),
    .forced_release (forced_release)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-requester queues of beats presented but not yet accepted.
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  int         seq [3];

  // Reference model of the arbiter registers.
  logic       m_busy;
  int         m_ptr;
  int         m_owner;
  logic [1:0] m_sel;
  int         m_cnt;
  logic       m_fr;
  int         wait_g [3];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_q(input int i, input logic [7:0] x);
    case (i)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  function automatic logic [8:0] pop_q(input int i);
    logic [8:0] r;
    r = 9'h000;
    case (i)
      0: if (q0.size() > 0) r = {1'b1, q0.pop_front()};
      1: if (q1.size() > 0) r = {1'b1, q1.pop_front()};
      default: if (q2.size() > 0) r = {1'b1, q2.pop_front()};
    endcase
    return r;
  endfunction

  function automatic void drop_last(input int i);
    case (i)
      0: if (q0.size() > 0) void'(q0.pop_back());
      1: if (q1.size() > 0) void'(q1.pop_back());
      default: if (q2.size() > 0) void'(q2.pop_back());
    endcase
  endfunction

  function automatic logic [7:0] next_data(input int i);
    seq[i]++;
    return 8'((i << 6) | (seq[i] & 63));
  endfunction

  task automatic present(input int i, input logic [7:0] x, input logic l);
    v[i]   = 1'b1;
    dat[i] = x;
    lst[i] = l;
    push_q(i, x);
  endtask

  task automatic withdraw_all();
    for (int i = 0; i < 3; i++) begin
      if (v[i]) drop_last(i);
      v[i]   = 1'b0;
      lst[i] = 1'b0;
    end
  endtask

  // One clock cycle: compare DUT against the model, advance the model, cross the edge.
  task automatic step(output int xid);
    logic [2:0] eg;
    logic       eov;
    logic [8:0] pq;
    int         c;
    logic       hit;
    xid = -1;
    #1;
    eg  = m_busy ? 3'(3'b001 << m_owner) : 3'b000;
    eov = m_busy && v[m_owner];
    if (!reset) begin
      check("grant", grant, eg);
      check("sel", sel, m_sel);
      check("forced_release", forced_release, m_fr);
      check("out_valid", out_valid, eov);
      check("req_ready", req_ready, ordy ? eg : 3'b000);
    end
    m_fr = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_ptr  = 2;
      m_sel  = 2'b00;
      m_cnt  = 0;
      for (int j = 0; j < 3; j++) wait_g[j] = 0;
    end else if (!m_busy) begin
      hit = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        c = (m_ptr + k) % 3;
        if (!hit && v[c]) begin
          hit     = 1'b1;
          m_owner = c;
          m_sel   = 2'(c);
          m_busy  = 1'b1;
          m_cnt   = 0;
        end
      end
      if (hit) begin
        check("starvation", (wait_g[m_owner] <= 2) ? 32'd1 : 32'd0, 32'd1);
        for (int j = 0; j < 3; j++) begin
          if (j == m_owner || !v[j]) wait_g[j] = 0;
          else wait_g[j]++;
        end
      end
    end else if (eov && ordy) begin
      xid = m_owner;
      pq  = pop_q(m_owner);
      check("scoreboard_nonempty", {31'd0, pq[8]}, 32'd1);
      check("out_data", out_data, pq[7:0]);
      m_cnt++;
      if (lst[m_owner] || m_cnt == MAX_BEATS) begin
        m_fr   = ~lst[m_owner];
        m_busy = 1'b0;
        m_ptr  = m_owner;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int x;
    withdraw_all();
    reset = 1'b1;
    step(x);
    step(x);
    reset = 1'b0;
  endtask

  logic [2:0] g_tbl [8];
  logic [1:0] s_tbl [8];

  initial begin
    int x;
    int nx;
    for (int i = 0; i < 3; i++) begin
      dat[i] = 8'h00;
      seq[i] = 0;
    end
    g_tbl = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    s_tbl = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};

    // Single beat from requester 0.
    do_reset();
    #1;
    check("rst_grant", grant, 3'b000);
    check("rst_sel", sel, 2'b00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_forced", forced_release, 1'b0);
    ordy = 1'b1;
    present(0, 8'h06, 1'b1);
    #1;
    check("t1_grant_before", grant, 3'b000);
    step(x);
    #1;
    check("t1_grant", grant, 3'b001);
    check("t1_sel", sel, 2'b00);
    check("t1_data", out_data, 8'h06);
    check("t1_ready", req_ready, 3'b001);
    step(x);
    check("t1_xfer_id", x, 0);
    if (x >= 0) v[x] = 1'b0;
    #1;
    check("t1_grant_after", grant, 3'b000);
    check("t1_ready_after", req_ready, 3'b000);
    step(x);

    // All three requesting, single-beat bursts.
    do_reset();
    for (int i = 0; i < 3; i++) present(i, next_data(i), 1'b1);
    for (int c = 0; c < 8; c++) begin
      #1;
      check("t2_grant_seq", grant, g_tbl[c]);
      check("t2_sel_seq", sel, s_tbl[c]);
      step(x);
      if (x >= 0) begin
        v[x] = 1'b0;
        present(x, next_data(x), 1'b1);
      end
    end
    withdraw_all();

    // Watchdog on a long burst of requester 1, requester 2 waiting.
    do_reset();
    present(1, 8'h08, 1'b0);
    present(2, 8'h20, 1'b1);
    nx = 0;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (c == 5) begin
        check("t3_forced", forced_release, 1'b1);
        check("t3_grant_idle", grant, 3'b000);
      end
      if (c == 6) begin
        check("t3_next_grant", grant, 3'b100);
        check("t3_forced_clear", forced_release, 1'b0);
      end
      step(x);
      if (x == 1) begin
        nx++;
        v[1] = 1'b0;
        present(1, 8'h08, 1'b0);
      end else if (x >= 0) begin
        v[x] = 1'b0;
      end
    end
    check("t3_beats", nx, 4);
    withdraw_all();

    // Stall from out_ready=0 mid-burst must not advance the beat count.
    do_reset();
    present(0, next_data(0), 1'b0);
    nx = 0;
    for (int c = 0; c < 9; c++) begin
      ordy = !(c >= 2 && c <= 4);
      #1;
      if (!ordy) begin
        check("t4_stall_valid", out_valid, 1'b1);
        check("t4_stall_ready", req_ready, 3'b000);
      end
      if (c == 7) check("t4_no_early_release", forced_release, 1'b0);
      if (c == 8) check("t4_forced", forced_release, 1'b1);
      step(x);
      if (x == 0) begin
        nx++;
        v[0] = 1'b0;
        present(0, next_data(0), 1'b0);
      end
    end
    check("t4_beats", nx, 4);
    withdraw_all();

    // Reset in the middle of a burst of requester 2.
    do_reset();
    ordy = 1'b1;
    present(2, next_data(2), 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(x);
      if (x >= 0) begin
        v[x] = 1'b0;
        present(x, next_data(x), 1'b0);
      end
    end
    present(0, next_data(0), 1'b1);
    present(1, next_data(1), 1'b1);
    #1;
    check("t5_busy", grant, 3'b100);
    reset = 1'b1;
    step(x);
    reset = 1'b0;
    #1;
    check("t5_grant", grant, 3'b000);
    check("t5_sel", sel, 2'b00);
    check("t5_out_valid", out_valid, 1'b0);
    step(x);
    #1;
    check("t5_first_grant", grant, 3'b001);
    step(x);
    if (x >= 0) v[x] = 1'b0;
    withdraw_all();

    // Random traffic against the model and scoreboard.
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) begin
        if (!v[i] && ($urandom_range(0, 1) == 1))
          present(i, next_data(i), $urandom_range(0, 2) == 0);
      end
      step(x);
      if (x >= 0) v[x] = 1'b0;
    end
    withdraw_all();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
